branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Next-PC control for the basic processor. Sits directly upstream of the program counter: decodes the branch field of the current instruction, evaluates the latched Zero flag, and drives the counter's absolute/relative jump requests and jump target. Holds a programmable jump-target lookup table, a return-address stack for CALL/RET, and a registered flush pulse for the fetch/decode stage.

## Interface
- L, 10: PC width; must equal the program counter width.
- D, 4: return-stack depth (entries), D ≥ 2.
- IW, 5: lookup-table index width; table has 2^IW entries of L bits.

- Clk  in  1  clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  core held; suppresses all branch activity while high.
- ProgCtr  in  L  current PC from the program counter.
- Op  in  3  branch opcode: 0 NONE, 1 JMP, 2 BRZ, 3 BRNZ, 4 CALL, 5 RET, 6 BR, 7 reserved (= NONE).
- Idx  in  IW  lookup-table index for the current instruction / table write.
- ZeroIn  in  1  Zero result from the ALU.
- FlagWe  in  1  latch ZeroIn into the flag register.
- LutWe  in  1  write LutData to table entry Idx.
- LutData  in  L  table write data.
- BranchAbs  out  1  absolute jump request to the program counter.
- BranchRel  out  1  relative jump request to the program counter.
- Target  out  L  jump target (absolute) or two's-complement offset (relative).
- Flush  out  1  registered; high the cycle after any taken branch.
- StackErr  out  1  sticky stack overflow/underflow flag.
- Depth  out  $clog2(D+1)  current return-stack occupancy.

## Operation
- BranchAbs, BranchRel and Target are combinational from Op, Idx, table, flag and stack. At most one request is high. When no branch is taken, Target = 0.
- JMP: BranchAbs = 1; Target = LUT[Idx].
- BR: BranchRel = 1; Target = LUT[Idx] (offset). PC wrap is modulo 2^L.
- BRZ: BranchRel = Zf. BRNZ: BranchRel = !Zf. Target = LUT[Idx] when taken.
- CALL: if Depth < D, BranchAbs = 1, Target = LUT[Idx], and (ProgCtr + 1) mod 2^L is pushed. If Depth == D: no branch, no push, StackErr set.
- RET: if Depth > 0, BranchAbs = 1, Target = top entry, pop. If Depth == 0: no branch, StackErr set.
- Start high: no requests, no push/pop, no Flush. Table writes and flag writes are still accepted.
- Flag Zf: updated from ZeroIn when FlagWe is high. A branch in the same cycle sees the old Zf.
- Table write: LUT[Idx] <= LutData. A branch in the same cycle reads the old entry.
- StackErr stays set until Reset.

## Timing
- Decision is zero latency: the program counter samples the requests at the same posedge.
- Stack push/pop, Zf, table and StackErr update at that same posedge.
- Flush is asserted exactly one cycle after a taken branch, for one cycle per taken branch. Back-to-back taken branches keep Flush high continuously.
- Reset (any cycle, including mid-CALL) clears the following, overriding every other input:
  - Zf = 0, Depth = 0, StackErr = 0, Flush = 0.
  - All table entries = 0.
  - All stack entries = 0.
- Requests and Target are combinational, so they are 0 while Op = NONE regardless of Reset.

## Configuration
- BRANCH_RAS_EN defined: return stack, CALL/RET semantics and StackErr as above.
- BRANCH_RAS_EN undefined: no stack storage.
  - CALL behaves exactly as JMP (no push).
  - RET behaves as NONE.
  - Depth and StackErr are tied to 0.

## Test plan
- Reset, then write LUT[3] = 10'h120 and issue Op = JMP, Idx = 3 -> BranchAbs = 1, Target = 10'h120; Flush = 1 on the next cycle only.
- FlagWe = 1 with ZeroIn = 1 in the same cycle as BRZ with LUT[2] = 10'h3FE -> not taken (old Zf = 0). Next cycle BRZ -> BranchRel = 1, Target = 10'h3FE (-2).
- With ProgCtr = 10'h3FF, CALL with LUT[1] = 10'h040 -> push 10'h000 (wrap), Depth = 1. Then RET -> BranchAbs = 1, Target = 10'h000, Depth = 0.
- With D = 4: five CALLs -> 5th not taken, Depth stays 4, StackErr = 1. Then five RETs -> 4 taken, 5th not taken, StackErr remains 1.
- Start = 1 with Op = CALL -> no request, Depth unchanged, Flush = 0.
- Reset asserted in the cycle of a CALL -> Depth = 0 and Flush = 0 next cycle. Without BRANCH_RAS_EN, the same CALL acts as JMP and Depth = 0 throughout.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// Bus between the next-PC controller and the fetch/PC logic.
// The slave modport is the controller side; the master modport is the core side.
interface branch_ctrl_if #(
  parameter int L  = 10,
  parameter int D  = 4,
  parameter int IW = 5
);
  localparam int DW = $clog2(D + 1);

  logic          Start;
  logic [L-1:0]  ProgCtr;
  logic [2:0]    Op;
  logic [IW-1:0] Idx;
  logic          ZeroIn;
  logic          FlagWe;
  logic          LutWe;
  logic [L-1:0]  LutData;
  logic          BranchAbs;
  logic          BranchRel;
  logic [L-1:0]  Target;
  logic          Flush;
  logic          StackErr;
  logic [DW-1:0] Depth;

  modport master (
    output Start, ProgCtr, Op, Idx, ZeroIn, FlagWe, LutWe, LutData,
    input  BranchAbs, BranchRel, Target, Flush, StackErr, Depth
  );

  modport slave (
    input  Start, ProgCtr, Op, Idx, ZeroIn, FlagWe, LutWe, LutData,
    output BranchAbs, BranchRel, Target, Flush, StackErr, Depth
  );
endinterface

// File: rtl/branch_ctrl.sv
// Next-PC control: branch decode, Zero flag, jump-target table and return stack.
// Define BRANCH_RAS_EN to build the return-address stack (CALL/RET, StackErr, Depth).
module branch_ctrl #(
  parameter int L  = 10,
  parameter int D  = 4,
  parameter int IW = 5
) (
  input logic         Clk,
  input logic         Reset,
  branch_ctrl_if.slave bus
);
  localparam int DW = $clog2(D + 1);
  localparam int NE = 1 << IW;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_JMP  = 3'd1,
    OP_BRZ  = 3'd2,
    OP_BRNZ = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_BR   = 3'd6,
    OP_RSV  = 3'd7
  } op_e;

  op_e          op;
  logic [L-1:0] lut [NE];
  logic [L-1:0] lut_rd;
  logic         zf;
  logic         flush_q;
  logic         req_abs;
  logic         req_rel;
  logic [L-1:0] tgt;

  assign op     = op_e'(bus.Op);
  assign lut_rd = lut[bus.Idx];

`ifdef BRANCH_RAS_EN
  localparam int SW = (D > 1) ? $clog2(D) : 1;

  logic [L-1:0]  stk [D];
  logic [DW-1:0] depth;
  logic [SW-1:0] wr_ptr;
  logic [SW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          err_set;
  logic          stk_err;

  // Slot indices only matter while depth is in range, so the low bits suffice.
  assign wr_ptr = depth[SW-1:0];
  assign rd_ptr = wr_ptr - SW'(1);
`endif

  always_comb begin
    req_abs = 1'b0;
    req_rel = 1'b0;
    tgt     = '0;
`ifdef BRANCH_RAS_EN
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
`endif
    if (!bus.Start) begin
      case (op)
        OP_JMP: begin
          req_abs = 1'b1;
          tgt     = lut_rd;
        end
        OP_BR: begin
          req_rel = 1'b1;
          tgt     = lut_rd;
        end
        OP_BRZ: begin
          if (zf) begin
            req_rel = 1'b1;
            tgt     = lut_rd;
          end
        end
        OP_BRNZ: begin
          if (!zf) begin
            req_rel = 1'b1;
            tgt     = lut_rd;
          end
        end
        OP_CALL: begin
`ifdef BRANCH_RAS_EN
          if (depth < DW'(D)) begin
            req_abs = 1'b1;
            tgt     = lut_rd;
            push    = 1'b1;
          end else begin
            err_set = 1'b1;
          end
`else
          req_abs = 1'b1;
          tgt     = lut_rd;
`endif
        end
        OP_RET: begin
`ifdef BRANCH_RAS_EN
          if (depth != '0) begin
            req_abs = 1'b1;
            tgt     = stk[rd_ptr];
            pop     = 1'b1;
          end else begin
            err_set = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Flag and table are written after the decode has read their old values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      zf      <= 1'b0;
      flush_q <= 1'b0;
      for (int i = 0; i < NE; i++) lut[i] <= '0;
    end else begin
      flush_q <= req_abs | req_rel;
      if (bus.FlagWe) zf <= bus.ZeroIn;
      if (bus.LutWe) lut[bus.Idx] <= bus.LutData;
    end
  end

`ifdef BRANCH_RAS_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      depth   <= '0;
      stk_err <= 1'b0;
      for (int i = 0; i < D; i++) stk[i] <= '0;
    end else begin
      if (push) begin
        stk[wr_ptr] <= bus.ProgCtr + L'(1);
        depth       <= depth + DW'(1);
      end else if (pop) begin
        depth <= depth - DW'(1);
      end
      if (err_set) stk_err <= 1'b1;
    end
  end

  assign bus.Depth    = depth;
  assign bus.StackErr = stk_err;
`else
  assign bus.Depth    = '0;
  assign bus.StackErr = 1'b0;
`endif

  assign bus.BranchAbs = req_abs;
  assign bus.BranchRel = req_rel;
  assign bus.Target    = tgt;
  assign bus.Flush     = flush_q;
endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed vector table, CALL/RET sequences, and
// random traffic against a queue-based reference model.
module tb_branch_ctrl;
  localparam int L  = 10;
  localparam int D  = 4;
  localparam int IW = 5;
`ifdef BRANCH_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic Clk;
  logic Reset;

  branch_ctrl_if #(.L(L), .D(D), .IW(IW)) bus ();
  branch_ctrl #(.L(L), .D(D), .IW(IW)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state
  logic [L-1:0] m_lut [1<<IW];
  logic [L-1:0] m_stk [$];
  bit           m_zf, m_err, m_flush;
  bit           e_abs, e_rel;
  logic [L-1:0] e_tgt;

  // Captured DUT outputs
  logic         c_abs, c_rel, r_flush, r_err;
  logic [L-1:0] c_tgt;
  logic [2:0]   r_depth;

  task automatic apply(input bit rst, input bit st, input bit [2:0] op, input bit [4:0] idx,
                       input bit [9:0] pc, input bit zin, input bit fwe, input bit lwe,
                       input bit [9:0] ld);
    bit do_push, do_pop, do_err;
    logic [L-1:0] ret_addr;
    Reset = rst; bus.Start = st; bus.Op = op; bus.Idx = idx; bus.ProgCtr = pc;
    bus.ZeroIn = zin; bus.FlagWe = fwe; bus.LutWe = lwe; bus.LutData = ld;
    e_abs = 0; e_rel = 0; e_tgt = '0; do_push = 0; do_pop = 0; do_err = 0;
    if (!st) begin
      case (op)
        3'd1: begin e_abs = 1; e_tgt = m_lut[idx]; end
        3'd6: begin e_rel = 1; e_tgt = m_lut[idx]; end
        3'd2: if (m_zf)  begin e_rel = 1; e_tgt = m_lut[idx]; end
        3'd3: if (!m_zf) begin e_rel = 1; e_tgt = m_lut[idx]; end
        3'd4: begin
          if (!RAS) begin e_abs = 1; e_tgt = m_lut[idx]; end
          else if (m_stk.size() < D) begin e_abs = 1; e_tgt = m_lut[idx]; do_push = 1; end
          else do_err = 1;
        end
        3'd5: begin
          if (RAS) begin
            if (m_stk.size() > 0) begin e_abs = 1; e_tgt = m_stk[$]; do_pop = 1; end
            else do_err = 1;
          end
        end
        default: ;
      endcase
    end
    #1;
    c_abs = bus.BranchAbs; c_rel = bus.BranchRel; c_tgt = bus.Target;
    @(posedge Clk);
    if (rst) begin
      foreach (m_lut[i]) m_lut[i] = '0;
      m_stk.delete();
      m_zf = 0; m_err = 0; m_flush = 0;
    end else begin
      if (fwe) m_zf = zin;
      if (lwe) m_lut[idx] = ld;
      ret_addr = pc + 10'd1;
      if (do_push) m_stk.push_back(ret_addr);
      if (do_pop) void'(m_stk.pop_back());
      if (do_err) m_err = 1;
      m_flush = e_abs | e_rel;
    end
    #1;
    r_flush = bus.Flush; r_err = bus.StackErr; r_depth = bus.Depth;
    @(negedge Clk);
  endtask

  typedef struct {
    bit rst, st; bit [2:0] op; bit [4:0] idx; bit [9:0] pc;
    bit zin, fwe, lwe; bit [9:0] ld;
    bit xa, xr; bit [9:0] xt; bit xf;
  } vec_t;

  vec_t tbl [17];

  initial begin
    //         rst st op  idx pc    zin fwe lwe ld       abs rel tgt     flush
    tbl[0]  = '{1, 0, 3'd0, 5'd0, 10'd0, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0};
    tbl[1]  = '{0, 0, 3'd0, 5'd3, 10'd0, 0, 0, 1, 10'h120, 0, 0, 10'h000, 0};
    tbl[2]  = '{0, 0, 3'd1, 5'd3, 10'd0, 0, 0, 0, 10'h000, 1, 0, 10'h120, 1};
    tbl[3]  = '{0, 0, 3'd0, 5'd3, 10'd0, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0};
    tbl[4]  = '{0, 0, 3'd0, 5'd2, 10'd0, 0, 0, 1, 10'h3FE, 0, 0, 10'h000, 0};
    tbl[5]  = '{0, 0, 3'd2, 5'd2, 10'd0, 1, 1, 0, 10'h000, 0, 0, 10'h000, 0};
    tbl[6]  = '{0, 0, 3'd2, 5'd2, 10'd0, 0, 0, 0, 10'h000, 0, 1, 10'h3FE, 1};
    tbl[7]  = '{0, 0, 3'd3, 5'd2, 10'd0, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0};
    tbl[8]  = '{0, 0, 3'd6, 5'd3, 10'd0, 0, 0, 0, 10'h000, 0, 1, 10'h120, 1};
    tbl[9]  = '{0, 0, 3'd1, 5'd3, 10'd0, 0, 0, 0, 10'h000, 1, 0, 10'h120, 1};
    tbl[10] = '{0, 0, 3'd7, 5'd3, 10'd0, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0};
    tbl[11] = '{0, 1, 3'd1, 5'd3, 10'd0, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0};
    tbl[12] = '{0, 1, 3'd0, 5'd4, 10'd0, 0, 0, 1, 10'h055, 0, 0, 10'h000, 0};
    tbl[13] = '{0, 0, 3'd1, 5'd4, 10'd0, 0, 0, 1, 10'h0AA, 1, 0, 10'h055, 1};
    tbl[14] = '{0, 0, 3'd1, 5'd4, 10'd0, 0, 0, 0, 10'h000, 1, 0, 10'h0AA, 1};
    tbl[15] = '{0, 0, 3'd3, 5'd2, 10'd0, 0, 1, 0, 10'h000, 0, 0, 10'h000, 0};
    tbl[16] = '{0, 0, 3'd3, 5'd2, 10'd0, 0, 0, 0, 10'h000, 0, 1, 10'h3FE, 1};

    Reset = 1; bus.Start = 0; bus.Op = 0; bus.Idx = 0; bus.ProgCtr = 0;
    bus.ZeroIn = 0; bus.FlagWe = 0; bus.LutWe = 0; bus.LutData = 0;
    @(negedge Clk);

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].rst, tbl[i].st, tbl[i].op, tbl[i].idx, tbl[i].pc,
            tbl[i].zin, tbl[i].fwe, tbl[i].lwe, tbl[i].ld);
      chk($sformatf("tbl%0d_abs", i), 32'(c_abs), 32'(tbl[i].xa));
      chk($sformatf("tbl%0d_rel", i), 32'(c_rel), 32'(tbl[i].xr));
      chk($sformatf("tbl%0d_tgt", i), 32'(c_tgt), 32'(tbl[i].xt));
      chk($sformatf("tbl%0d_flush", i), 32'(r_flush), 32'(tbl[i].xf));
      if (i == 0) begin
        chk("reset_depth", 32'(r_depth), 32'd0);
        chk("reset_err", 32'(r_err), 32'd0);
      end
    end

    // CALL at the top of the address space: return address wraps to 0.
    apply(1, 0, 3'd0, 5'd0, 10'd0, 0, 0, 0, 10'd0);
    apply(0, 0, 3'd0, 5'd1, 10'd0, 0, 0, 1, 10'h040);
    apply(0, 0, 3'd4, 5'd1, 10'h3FF, 0, 0, 0, 10'd0);
    chk("wrap_call_abs", 32'(c_abs), 32'd1);
    chk("wrap_call_tgt", 32'(c_tgt), 32'h040);
    chk("wrap_call_depth", 32'(r_depth), RAS ? 32'd1 : 32'd0);
    apply(0, 0, 3'd5, 5'd1, 10'h040, 0, 0, 0, 10'd0);
    chk("wrap_ret_abs", 32'(c_abs), 32'(RAS));
    chk("wrap_ret_tgt", 32'(c_tgt), 32'h000);
    chk("wrap_ret_depth", 32'(r_depth), 32'd0);
    chk("wrap_ret_flush", 32'(r_flush), 32'(RAS));

    // Overflow then underflow of the return stack.
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 3'd4, 5'd1, 10'(i), 0, 0, 0, 10'd0);
      chk($sformatf("ovf%0d_abs", i), 32'(c_abs), RAS ? 32'(i < 4) : 32'd1);
      chk($sformatf("ovf%0d_depth", i), 32'(r_depth), RAS ? 32'((i < 4) ? i + 1 : 4) : 32'd0);
      chk($sformatf("ovf%0d_err", i), 32'(r_err), 32'(RAS && i == 4));
    end
    for (int j = 0; j < 5; j++) begin
      apply(0, 0, 3'd5, 5'd1, 10'd0, 0, 0, 0, 10'd0);
      chk($sformatf("unf%0d_abs", j), 32'(c_abs), 32'(RAS && j < 4));
      chk($sformatf("unf%0d_tgt", j), 32'(c_tgt), (RAS && j < 4) ? 32'(4 - j) : 32'd0);
      chk($sformatf("unf%0d_depth", j), 32'(r_depth), RAS ? 32'((j < 3) ? 3 - j : 0) : 32'd0);
      chk($sformatf("unf%0d_err", j), 32'(r_err), 32'(RAS));
    end

    // Start holds the core: CALL does nothing.
    apply(0, 0, 3'd4, 5'd1, 10'd5, 0, 0, 0, 10'd0);
    apply(0, 1, 3'd4, 5'd1, 10'd6, 0, 0, 0, 10'd0);
    chk("start_abs", 32'(c_abs), 32'd0);
    chk("start_tgt", 32'(c_tgt), 32'd0);
    chk("start_flush", 32'(r_flush), 32'd0);
    chk("start_depth", 32'(r_depth), RAS ? 32'd1 : 32'd0);

    // Reset in the cycle of a CALL wins over the push.
    apply(1, 0, 3'd4, 5'd1, 10'd7, 0, 0, 0, 10'd0);
    chk("rstcall_depth", 32'(r_depth), 32'd0);
    chk("rstcall_flush", 32'(r_flush), 32'd0);
    chk("rstcall_err", 32'(r_err), 32'd0);

    // Random traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      bit rst, st, fwe, lwe, zin;
      rst = ($urandom_range(0, 63) == 0);
      st  = ($urandom_range(0, 7) == 0);
      fwe = $urandom_range(0, 1);
      zin = $urandom_range(0, 1);
      lwe = ($urandom_range(0, 3) == 0);
      apply(rst, st, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            10'($urandom), zin, fwe, lwe, 10'($urandom));
      chk("rnd_abs", 32'(c_abs), 32'(e_abs));
      chk("rnd_rel", 32'(c_rel), 32'(e_rel));
      chk("rnd_tgt", 32'(c_tgt), 32'(e_tgt));
      chk("rnd_flush", 32'(r_flush), 32'(m_flush));
      chk("rnd_depth", 32'(r_depth), 32'(m_stk.size()));
      chk("rnd_err", 32'(r_err), 32'(m_err));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
